// File: rtl/axrm_pkg.sv
// Shared definitions for the approximate-multiplier error sweep: default width,
// sweep state encoding and the pair-count helper.
package axrm_pkg;

    localparam int AXRM_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of operand pairs in an exhaustive W x W sweep.
    function automatic int unsigned pair_count(input int unsigned w);
        return 32'd1 << (2 * w);
    endfunction

endpackage

// File: rtl/axrm_err_acc.sv
// Error accumulator: absolute error distance, saturating distance sum, worst case
// and exact-match count. Optional worst-case operand trace under AXRM_WCE_TRACE_EN.
module axrm_err_acc #(
    parameter int W     = 4,
    parameter int CNT_W = 2 * W + 1,
    parameter int SUM_W = 4 * W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [2*W-1:0]   exact,
    input  logic [2*W-1:0]   approx,
`ifdef AXRM_WCE_TRACE_EN
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic [W-1:0]     wce_a,
    output logic [W-1:0]     wce_b,
`endif
    output logic [CNT_W-1:0] correct_cnt,
    output logic [SUM_W-1:0] ed_sum,
    output logic [2*W-1:0]   ed_max
);

    logic [2*W:0]   diff;
    logic [2*W-1:0] ed;
    logic [SUM_W:0] sum_ext;

    // The extra sign bit of the widened subtract selects which direction to take.
    assign diff    = {1'b0, exact} - {1'b0, approx};
    assign ed      = diff[2*W] ? (approx - exact) : diff[2*W-1:0];
    assign sum_ext = {1'b0, ed_sum} + (SUM_W + 1)'(ed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            correct_cnt <= '0;
            ed_sum      <= '0;
            ed_max      <= '0;
`ifdef AXRM_WCE_TRACE_EN
            wce_a       <= '0;
            wce_b       <= '0;
`endif
        end else if (clr) begin
            correct_cnt <= '0;
            ed_sum      <= '0;
            ed_max      <= '0;
`ifdef AXRM_WCE_TRACE_EN
            wce_a       <= '0;
            wce_b       <= '0;
`endif
        end else if (in_vld) begin
            correct_cnt <= correct_cnt + {{(CNT_W-1){1'b0}}, (ed == '0)};
            // Clamp at all-ones when a narrow sum width is chosen.
            ed_sum      <= sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
            if (ed > ed_max) begin
                ed_max <= ed;
`ifdef AXRM_WCE_TRACE_EN
                wce_a  <= in_a;
                wce_b  <= in_b;
`endif
            end
        end
    end

endmodule

// File: rtl/axrm_err_sweep.sv
// Exhaustive error sweep around an external combinational multiplier: pair
// counter, FSM and capture stage; AXRM_WCE_TRACE_EN adds worst-case operand outputs.
module axrm_err_sweep
    import axrm_pkg::*;
#(
    parameter int W     = AXRM_W,
    parameter int CNT_W = 2 * W + 1,
    parameter int SUM_W = 4 * W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    output logic             op_vld,
    input  logic [2*W-1:0]   approx_y,
    output logic             busy,
    output logic             done,
`ifdef AXRM_WCE_TRACE_EN
    output logic [W-1:0]     wce_a,
    output logic [W-1:0]     wce_b,
`endif
    output logic [CNT_W-1:0] correct_cnt,
    output logic [SUM_W-1:0] ed_sum,
    output logic [2*W-1:0]   ed_max
);

    localparam logic [2*W-1:0] IDX_LAST = (2 * W)'(pair_count(W) - 1);

    state_t         state;
    logic [2*W-1:0] idx;
    logic           start_accept;

    logic           s1_vld;
    logic [2*W-1:0] s1_exact;
    logic [2*W-1:0] s1_approx;
`ifdef AXRM_WCE_TRACE_EN
    logic [W-1:0]   s1_a;
    logic [W-1:0]   s1_b;
`endif

    assign start_accept = start && ((state == IDLE) || (state == DONE));

    // The pair index is the operand register: A is the outer loop, B the inner.
    assign op_a = idx[2*W-1:W];
    assign op_b = idx[W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            op_vld <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= RUN;
                        idx    <= '0;
                        op_vld <= 1'b1;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                RUN: begin
                    if (idx == IDX_LAST) begin
                        state  <= DRAIN;
                        op_vld <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture stage: exact reference and returned approximation for the same pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_exact  <= '0;
            s1_approx <= '0;
`ifdef AXRM_WCE_TRACE_EN
            s1_a      <= '0;
            s1_b      <= '0;
`endif
        end else if (start_accept) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= op_vld;
            if (op_vld) begin
                s1_exact  <= {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
                s1_approx <= approx_y;
`ifdef AXRM_WCE_TRACE_EN
                s1_a      <= op_a;
                s1_b      <= op_b;
`endif
            end
        end
    end

    axrm_err_acc #(
        .W     (W),
        .CNT_W (CNT_W),
        .SUM_W (SUM_W)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .clr         (start_accept),
        .in_vld      (s1_vld),
        .exact       (s1_exact),
        .approx      (s1_approx),
`ifdef AXRM_WCE_TRACE_EN
        .in_a        (s1_a),
        .in_b        (s1_b),
        .wce_a       (wce_a),
        .wce_b       (wce_b),
`endif
        .correct_cnt (correct_cnt),
        .ed_sum      (ed_sum),
        .ed_max      (ed_max)
    );

endmodule

// File: tb/tb_axrm_err_sweep.sv
// Directed bench for axrm_err_sweep: stand-in multipliers with hand-computed
// statistics, latency, restart handling and asynchronous reset.
module tb_axrm_err_sweep;

    localparam int W     = 4;
    localparam int CNT_W = 2 * W + 1;
    localparam int SUM_W = 4 * W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             op_vld;
    logic [2*W-1:0]   approx_y;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] correct_cnt;
    logic [SUM_W-1:0] ed_sum;
    logic [2*W-1:0]   ed_max;
`ifdef AXRM_WCE_TRACE_EN
    logic [W-1:0]     wce_a;
    logic [W-1:0]     wce_b;
`endif

    int               mode;
    logic [2*W-1:0]   prod;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    // Stand-in multipliers: 0 exact, 1 tied zero, 2 LSB cleared, 3 LSB set, 4 all-ones.
    always_comb begin
        prod     = {4'b0000, op_a} * {4'b0000, op_b};
        approx_y = prod;
        case (mode)
            1:       approx_y = 8'h00;
            2:       approx_y = prod & 8'hFE;
            3:       approx_y = prod | 8'h01;
            4:       approx_y = 8'hFF;
            default: approx_y = prod;
        endcase
    end

    axrm_err_sweep #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_vld      (op_vld),
        .approx_y    (approx_y),
        .busy        (busy),
        .done        (done),
`ifdef AXRM_WCE_TRACE_EN
        .wce_a       (wce_a),
        .wce_b       (wce_b),
`endif
        .correct_cnt (correct_cnt),
        .ed_sum      (ed_sum),
        .ed_max      (ed_max)
    );

    // Pulses start, records {busy,op_vld,done} and correct_cnt just after the
    // accepting edge, then counts edges until done (bounded). restart_at re-pulses start.
    task automatic run_sweep(input int restart_at, output int edges,
                             output logic [2:0] flags, output logic [CNT_W-1:0] cnt0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        flags = {busy, op_vld, done};
        cnt0  = correct_cnt;
        edges = 0;
        while (edges < 400) begin
            @(posedge clk);
            #1;
            edges++;
            start = (edges == restart_at);
            if (done) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        checks++; if (op_a !== 4'd0 || op_b !== 4'd0) begin errors++; $display("FAIL reset_ops got=%0d/%0d exp=0/0", op_a, op_b); end
        checks++; if ({op_vld, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {op_vld, busy, done}); end
        checks++; if (correct_cnt !== 9'd0) begin errors++; $display("FAIL reset_correct got=%0d exp=0", correct_cnt); end
        checks++; if (ed_sum !== 16'd0) begin errors++; $display("FAIL reset_sum got=%0d exp=0", ed_sum); end
        checks++; if (ed_max !== 8'd0) begin errors++; $display("FAIL reset_max got=%0d exp=0", ed_max); end
`ifdef AXRM_WCE_TRACE_EN
        checks++; if (wce_a !== 4'd0 || wce_b !== 4'd0) begin errors++; $display("FAIL reset_wce got=%0d/%0d exp=0/0", wce_a, wce_b); end
`endif
        $display("reset: outputs idle");
    endtask

    // Shared result check for a completed sweep; all expectations passed in by the caller.
    task automatic test_sweep(input string name, input int m, input int restart_at,
                              input int exp_cnt, input int exp_sum, input int exp_max,
                              input int exp_wa, input int exp_wb);
        int edges;
        logic [2:0] flags;
        logic [CNT_W-1:0] cnt0;
        mode = m;
        run_sweep(restart_at, edges, flags, cnt0);
        $display("%s: edges=%0d correct=%0d sum=%0d max=%0d", name, edges, correct_cnt, ed_sum, ed_max);
        checks++; if (edges !== 257) begin errors++; $display("FAIL %s_latency got=%0d exp=257", name, edges); end
        checks++; if (flags !== 3'b110) begin errors++; $display("FAIL %s_accept_flags got=%b exp=110", name, flags); end
        checks++; if (cnt0 !== 9'd0) begin errors++; $display("FAIL %s_cleared got=%0d exp=0", name, cnt0); end
        checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL %s_done_flags got=%b exp=01", name, {busy, done}); end
        checks++; if (correct_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL %s_correct got=%0d exp=%0d", name, correct_cnt, exp_cnt); end
        checks++; if (ed_sum !== SUM_W'(exp_sum)) begin errors++; $display("FAIL %s_sum got=%0d exp=%0d", name, ed_sum, exp_sum); end
        checks++; if (ed_max !== 8'(exp_max)) begin errors++; $display("FAIL %s_max got=%0d exp=%0d", name, ed_max, exp_max); end
`ifdef AXRM_WCE_TRACE_EN
        checks++; if (wce_a !== 4'(exp_wa) || wce_b !== 4'(exp_wb)) begin errors++; $display("FAIL %s_wce got=%0d/%0d exp=%0d/%0d", name, wce_a, wce_b, exp_wa, exp_wb); end
`else
        if (exp_wa < 0 || exp_wb < 0) $display("%s: negative trace expectation ignored", name);
`endif
    endtask

    task automatic test_done_hold();
        repeat (5) @(negedge clk);
        checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL hold_flags got=%b exp=01", {busy, done}); end
        checks++; if (correct_cnt !== 9'd0 || ed_sum !== 16'd50880 || ed_max !== 8'd255) begin
            errors++; $display("FAIL hold_stats got=%0d/%0d/%0d exp=0/50880/255", correct_cnt, ed_sum, ed_max); end
        $display("done_hold: stable after 5 cycles");
    endtask

    task automatic test_reset_mid_run();
        int n;
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (n < 300 && !(op_vld && op_a == 4'd8 && op_b == 4'd0)) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n >= 300) begin errors++; $display("FAIL midrst_reach got=%0d exp=<300", n); end
        rst = 1'b1;
        #1;
        checks++; if ({op_a, op_b} !== 8'h00 || {op_vld, busy, done} !== 3'b000) begin
            errors++; $display("FAIL midrst_ctrl got=%h/%b exp=00/000", {op_a, op_b}, {op_vld, busy, done}); end
        checks++; if (correct_cnt !== 9'd0 || ed_sum !== 16'd0 || ed_max !== 8'd0) begin
            errors++; $display("FAIL midrst_stats got=%0d/%0d/%0d exp=0/0/0", correct_cnt, ed_sum, ed_max); end
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({op_vld, busy, done} !== 3'b000) begin errors++; $display("FAIL midrst_idle got=%b exp=000", {op_vld, busy, done}); end
        $display("reset_mid_run: cleared at idx 0x80");
        test_sweep("after_reset", 0, -1, 256, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode = 0;
        test_reset();
        test_sweep("exact", 0, -1, 256, 0, 0, 0, 0);
        test_sweep("back_to_back", 2, -1, 192, 64, 1, 1, 1);
        test_sweep("tied_zero", 1, -1, 31, 14400, 225, 15, 15);
        test_sweep("lsb_set", 3, -1, 64, 192, 1, 0, 0);
        test_sweep("all_ones", 4, -1, 0, 50880, 255, 0, 0);
        test_done_hold();
        test_sweep("restart_ignored", 1, 100, 31, 14400, 225, 15, 15);
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
